// File: rtl/mem_burst_arb_pkg.sv
// Shared types and default widths for the two-port burst arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, BUSY, ZERO)
//   burst_t : direction of the latched burst (WR, RD)
package mem_burst_arb_pkg;

  localparam int DATA_BITS_DEF = 128;
  localparam int ADDR_BITS_DEF = 24;
  localparam int LEN_BITS_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    ZERO  = 2'd3
  } state_t;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } burst_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker.
//   mem_clk, rst_n : clock, asynchronous active-low reset
//   enable         : picking allowed this cycle
//   req[1:0]       : per-port request (any type)
//   grant[1:0]     : one-hot winner, combinational, zero when disabled
// The pointer remembers the last granted port; on a tie the other port wins.
// It resets to "port 1 granted last" so port 0 is preferred after reset.
module rr_arb2 (
  input  logic       mem_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/mem_burst_arb.sv
// Shares one burst-engine user interface between two requesters, one whole
// burst at a time, round-robin fair.
//   mem_clk, rst_n, init_done        : clock, async reset, calibration done
//   pN_wr_req/pN_rd_req/pN_len/pN_addr : port N command (level, held to ack)
//   pN_ack, pN_finish                : one-cycle accept / complete pulses
//   pN_wr_data_req, pN_wr_data       : write-data handshake, owner only
//   pN_rd_data_valid, pN_rd_data     : read data (valid gated to owner)
//   wr_/rd_burst_*                   : burst engine interface
//   dbg_state                        : current FSM state
// Handshake: a port holds its request level with len/addr stable until the
// cycle its ack pulses; it must drop the request in the following cycle or
// it is taken as a new command. The engine request is held until the first
// data strobe of the burst and drops the cycle after that strobe.
module mem_burst_arb
  import mem_burst_arb_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF
) (
  input  logic                 mem_clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  input  logic                 p0_wr_req,
  input  logic                 p0_rd_req,
  input  logic [LEN_BITS-1:0]  p0_len,
  input  logic [ADDR_BITS-1:0] p0_addr,
  output logic                 p0_ack,
  output logic                 p0_wr_data_req,
  input  logic [DATA_BITS-1:0] p0_wr_data,
  output logic                 p0_rd_data_valid,
  output logic [DATA_BITS-1:0] p0_rd_data,
  output logic                 p0_finish,
  input  logic                 p1_wr_req,
  input  logic                 p1_rd_req,
  input  logic [LEN_BITS-1:0]  p1_len,
  input  logic [ADDR_BITS-1:0] p1_addr,
  output logic                 p1_ack,
  output logic                 p1_wr_data_req,
  input  logic [DATA_BITS-1:0] p1_wr_data,
  output logic                 p1_rd_data_valid,
  output logic [DATA_BITS-1:0] p1_rd_data,
  output logic                 p1_finish,
  output logic                 wr_burst_req,
  output logic                 rd_burst_req,
  output logic [LEN_BITS-1:0]  wr_burst_len,
  output logic [LEN_BITS-1:0]  rd_burst_len,
  output logic [ADDR_BITS-1:0] wr_burst_addr,
  output logic [ADDR_BITS-1:0] rd_burst_addr,
  input  logic                 wr_burst_data_req,
  output logic [DATA_BITS-1:0] wr_burst_data,
  input  logic                 rd_burst_data_valid,
  input  logic [DATA_BITS-1:0] rd_burst_data,
  input  logic                 burst_finish,
  output state_t               dbg_state
);

  state_t               state;
  burst_t               btype;
  logic                 gnt_port;
  logic [LEN_BITS-1:0]  lat_len;
  logic [ADDR_BITS-1:0] lat_addr;
  logic                 wr_req_q;
  logic                 rd_req_q;

  logic [1:0]           port_req;
  logic [1:0]           grant;
  logic                 pick_en;
  logic                 win_port;
  logic                 win_wr;
  logic [LEN_BITS-1:0]  win_len;
  logic [ADDR_BITS-1:0] win_addr;
  logic                 active;
  logic                 first_strobe;
  logic                 fin_any;

  assign port_req = {p1_wr_req | p1_rd_req, p0_wr_req | p0_rd_req};
  // rst_n in the enable keeps ack low while reset is held.
  assign pick_en  = rst_n & init_done & (state == IDLE);

  rr_arb2 u_rr (
    .mem_clk (mem_clk),
    .rst_n   (rst_n),
    .enable  (pick_en),
    .req     (port_req),
    .grant   (grant)
  );

  assign win_port = grant[1];
  // Write wins when a port raises both request types.
  assign win_wr   = win_port ? p1_wr_req : p0_wr_req;
  assign win_len  = win_port ? p1_len    : p0_len;
  assign win_addr = win_port ? p1_addr   : p0_addr;

  assign p0_ack = grant[0];
  assign p1_ack = grant[1];

  assign first_strobe = (btype == WR) ? wr_burst_data_req : rd_burst_data_valid;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      btype    <= WR;
      gnt_port <= 1'b0;
      lat_len  <= '0;
      lat_addr <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            gnt_port <= win_port;
            btype    <= win_wr ? WR : RD;
            lat_len  <= win_len;
            lat_addr <= win_addr;
            if (win_len == '0) begin
              state <= ZERO;
            end else begin
              state    <= ISSUE;
              wr_req_q <= win_wr;
              rd_req_q <= ~win_wr;
            end
          end
        end
        ISSUE: begin
          if (burst_finish || first_strobe) begin
            state    <= burst_finish ? IDLE : BUSY;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
          end
        end
        BUSY: begin
          if (burst_finish) begin
            state <= IDLE;
          end
        end
        ZERO: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wr_burst_req  = wr_req_q;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_len  = lat_len;
  assign rd_burst_len  = lat_len;
  assign wr_burst_addr = lat_addr;
  assign rd_burst_addr = lat_addr;
  assign dbg_state     = state;

  // Engine strobes are only meaningful while a burst is on the engine;
  // anything arriving in IDLE or ZERO is dropped.
  assign active = (state == ISSUE) || (state == BUSY);

  assign p0_wr_data_req   = wr_burst_data_req & active & (btype == WR) & ~gnt_port;
  assign p1_wr_data_req   = wr_burst_data_req & active & (btype == WR) &  gnt_port;
  assign p0_rd_data_valid = rd_burst_data_valid & active & (btype == RD) & ~gnt_port;
  assign p1_rd_data_valid = rd_burst_data_valid & active & (btype == RD) &  gnt_port;

  assign wr_burst_data = active ? (gnt_port ? p1_wr_data : p0_wr_data) : '0;
  assign p0_rd_data    = rd_burst_data;
  assign p1_rd_data    = rd_burst_data;

  // A zero-length burst completes by itself in its single ZERO cycle.
  assign fin_any   = (active & burst_finish) | (state == ZERO);
  assign p0_finish = fin_any & ~gnt_port;
  assign p1_finish = fin_any &  gnt_port;

endmodule

// File: tb/tb_mem_burst_arb.sv
module tb_mem_burst_arb;
  import mem_burst_arb_pkg::*;

  localparam int DW = 128;
  localparam int AW = 24;
  localparam int LW = 10;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [LW-1:0] len;
    logic [AW-1:0] addr;
  } cmd_t;

  logic          mem_clk, rst_n, init_done;
  logic          p0_wr_req, p0_rd_req, p0_ack, p0_wr_data_req, p0_rd_data_valid, p0_finish;
  logic          p1_wr_req, p1_rd_req, p1_ack, p1_wr_data_req, p1_rd_data_valid, p1_finish;
  logic [LW-1:0] p0_len, p1_len, wr_burst_len, rd_burst_len;
  logic [AW-1:0] p0_addr, p1_addr, wr_burst_addr, rd_burst_addr;
  logic [DW-1:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
  logic [DW-1:0] wr_burst_data, rd_burst_data;
  logic          wr_burst_req, rd_burst_req, wr_burst_data_req, rd_burst_data_valid, burst_finish;
  state_t        dbg_state;

  mem_burst_arb dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .init_done(init_done),
    .p0_wr_req(p0_wr_req), .p0_rd_req(p0_rd_req), .p0_len(p0_len), .p0_addr(p0_addr),
    .p0_ack(p0_ack), .p0_wr_data_req(p0_wr_data_req), .p0_wr_data(p0_wr_data),
    .p0_rd_data_valid(p0_rd_data_valid), .p0_rd_data(p0_rd_data), .p0_finish(p0_finish),
    .p1_wr_req(p1_wr_req), .p1_rd_req(p1_rd_req), .p1_len(p1_len), .p1_addr(p1_addr),
    .p1_ack(p1_ack), .p1_wr_data_req(p1_wr_data_req), .p1_wr_data(p1_wr_data),
    .p1_rd_data_valid(p1_rd_data_valid), .p1_rd_data(p1_rd_data), .p1_finish(p1_finish),
    .wr_burst_req(wr_burst_req), .rd_burst_req(rd_burst_req),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .wr_burst_addr(wr_burst_addr), .rd_burst_addr(rd_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .burst_finish(burst_finish), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    mem_clk = 1'b0;
    forever #5 mem_clk = ~mem_clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [0:0] exp_q[$];
  cmd_t       cq0[$];
  cmd_t       cq1[$];
  logic [1:0] port_busy = 2'b00;
  logic       model_last = 1'b1;
  int         cyc = 0, ack_cyc = 0, fin_cyc = 0, last_gap = 0;
  int         n_acks = 0, n_fins = 0, eng_bursts = 0, cnt = 0;
  logic       in_flight = 1'b0;
  logic       mon_port, mon_wr;
  logic [LW-1:0] mon_len;
  logic [AW-1:0] mon_addr;
  int         stray_req = 0, stray_seen = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected grant order: while both ports have work they alternate,
  // starting with the port not granted last; leftovers go in order.
  task automatic plan_order(input int a, input int b);
    logic pref;
    pref = ~model_last;
    while (a > 0 || b > 0) begin
      if (a > 0 && b > 0) begin
        exp_q.push_back(pref);
        if (pref == 1'b0) a--; else b--;
        pref = ~pref;
      end else if (a > 0) begin
        exp_q.push_back(1'b0);
        a--;
      end else begin
        exp_q.push_back(1'b1);
        b--;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_port(input int n, input logic wr, input logic rd,
                            input logic [LW-1:0] len, input logic [AW-1:0] addr);
    if (n == 0) begin
      p0_wr_req = wr; p0_rd_req = rd; p0_len = len; p0_addr = addr;
    end else begin
      p1_wr_req = wr; p1_rd_req = rd; p1_len = len; p1_addr = addr;
    end
  endtask

  task automatic run_port(input int n);
    cmd_t c;
    bit   got;
    port_busy[n] = 1'b1;
    while ((n == 0 ? cq0.size() : cq1.size()) > 0) begin
      @(posedge mem_clk); #1;
      if (n == 0) c = cq0.pop_front(); else c = cq1.pop_front();
      drive_port(n, c.wr, c.rd, c.len, c.addr);
      got = 0;
      for (int t = 0; t < 3000; t++) begin
        @(negedge mem_clk);
        if (!rst_n) break;
        if ((n == 0) ? p0_ack : p1_ack) begin got = 1; break; end
      end
      if (rst_n) chk("ack_wait", got, 1);
      @(posedge mem_clk); #1;
      drive_port(n, 1'b0, 1'b0, c.len, c.addr);
      got = 0;
      for (int t = 0; t < 3000; t++) begin
        @(negedge mem_clk);
        if (!rst_n) break;
        if ((n == 0) ? p0_finish : p1_finish) begin got = 1; break; end
      end
      if (rst_n) chk("fin_wait", got, 1);
      else begin
        if (n == 0) cq0.delete(); else cq1.delete();
      end
    end
    port_busy[n] = 1'b0;
  endtask

  task automatic run_both();
    fork
      run_port(0);
      run_port(1);
    join
    @(posedge mem_clk); #1;
  endtask

  task automatic wait_ports_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 5000; t++) begin
      if (port_busy == 2'b00) begin ok = 1; break; end
      @(posedge mem_clk); #1;
    end
    chk("ports_idle_wait", ok, 1);
  endtask

  task automatic wait_state(input state_t s);
    bit ok;
    ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(posedge mem_clk); #1;
      if (dbg_state == s) begin ok = 1; break; end
    end
    chk("state_wait", ok, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wr_burst_req"}, wr_burst_req, 0);
    chk({tag, "_rd_burst_req"}, rd_burst_req, 0);
    chk({tag, "_acks"}, {p1_ack, p0_ack}, 0);
    chk({tag, "_finish"}, {p1_finish, p0_finish}, 0);
    chk({tag, "_wr_data_req"}, {p1_wr_data_req, p0_wr_data_req}, 0);
    chk({tag, "_rd_valid"}, {p1_rd_data_valid, p0_rd_data_valid}, 0);
    chk({tag, "_len"}, {wr_burst_len, rd_burst_len}, 0);
    chk({tag, "_addr"}, {wr_burst_addr, rd_burst_addr}, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- write data sources ----------------
  initial begin
    p0_wr_data = '0;
    p1_wr_data = '0;
    forever begin
      @(posedge mem_clk); #1;
      p0_wr_data = {$urandom, $urandom, $urandom, $urandom};
      p1_wr_data = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // ---------------- burst engine model ----------------
  initial begin
    bit            e_wr, first;
    int            e_len, k, wait_n;
    logic [AW-1:0] e_addr;
    wr_burst_data_req = 0; rd_burst_data_valid = 0; burst_finish = 0; rd_burst_data = '0;
    forever begin
      @(posedge mem_clk); #1;
      wr_burst_data_req = 0; rd_burst_data_valid = 0; burst_finish = 0;
      if (stray_req != stray_seen) begin
        stray_seen = stray_req;
        wr_burst_data_req = 1; rd_burst_data_valid = 1; burst_finish = 1;
      end else if (rst_n && (wr_burst_req || rd_burst_req)) begin
        eng_bursts++;
        e_wr   = wr_burst_req;
        e_len  = int'(e_wr ? wr_burst_len : rd_burst_len);
        e_addr = e_wr ? wr_burst_addr : rd_burst_addr;
        chk("eng_both_req", wr_burst_req & rd_burst_req, 0);
        chk("eng_type", e_wr, mon_wr);
        chk("eng_len", e_len, mon_len);
        chk("eng_addr", e_addr, mon_addr);
        wait_n = $urandom_range(0, 2);
        k = 0;
        first = 0;
        while (k < e_len) begin
          chk("eng_req_hold", wr_burst_req | rd_burst_req, !first);
          if (wait_n > 0) begin
            wait_n--;
          end else if ($urandom_range(0, 3) != 0) begin
            if (e_wr) wr_burst_data_req = 1;
            else begin
              rd_burst_data_valid = 1;
              rd_burst_data = {$urandom, $urandom, $urandom, $urandom};
            end
            k++;
            first = 1;
          end
          @(posedge mem_clk); #1;
          wr_burst_data_req = 0; rd_burst_data_valid = 0;
          if (!rst_n) break;
        end
        if (rst_n) begin
          repeat ($urandom_range(0, 2)) begin @(posedge mem_clk); #1; end
          burst_finish = rst_n;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge mem_clk) begin
    logic       a_port;
    logic [3:0] exp_route;
    cyc++;
    if (!rst_n) begin
      in_flight = 0;
    end else begin
      if (!in_flight && (wr_burst_data_req || rd_burst_data_valid || burst_finish))
        chk("idle_strobe_fwd", {p1_wr_data_req, p0_wr_data_req, p1_rd_data_valid,
                                p0_rd_data_valid, p1_finish, p0_finish}, 0);
      if (p0_ack || p1_ack) begin
        chk("ack_onehot", p0_ack & p1_ack, 0);
        a_port = p1_ack;
        if (exp_q.size() == 0) chk("ack_unexpected", a_port, 1'bx);
        else chk("grant_order", a_port, exp_q.pop_front());
        mon_port  = a_port;
        mon_wr    = a_port ? p1_wr_req : p0_wr_req;
        mon_len   = a_port ? p1_len : p0_len;
        mon_addr  = a_port ? p1_addr : p0_addr;
        cnt       = 0;
        last_gap  = cyc - fin_cyc;
        ack_cyc   = cyc;
        in_flight = 1;
        model_last = a_port;
        n_acks++;
      end
      if (in_flight && (wr_burst_data_req || rd_burst_data_valid)) begin
        if (mon_wr) exp_route = {mon_port & wr_burst_data_req, ~mon_port & wr_burst_data_req, 2'b00};
        else exp_route = {2'b00, mon_port & rd_burst_data_valid, ~mon_port & rd_burst_data_valid};
        chk("route", {p1_wr_data_req, p0_wr_data_req, p1_rd_data_valid, p0_rd_data_valid}, exp_route);
        if (mon_wr && wr_burst_data_req) begin
          cnt++;
          chk("wr_data_mux", wr_burst_data, mon_port ? p1_wr_data : p0_wr_data);
        end
        if (!mon_wr && rd_burst_data_valid) begin
          cnt++;
          chk("rd_data", mon_port ? p1_rd_data : p0_rd_data, rd_burst_data);
        end
      end
      if (p0_finish || p1_finish) begin
        chk("fin_onehot", p0_finish & p1_finish, 0);
        if (!in_flight) chk("fin_unexpected", {p1_finish, p0_finish}, 0);
        else begin
          chk("fin_port", p1_finish, mon_port);
          chk("strobe_count", cnt, mon_len);
          if (mon_len == 0) chk("zero_len_latency", cyc - ack_cyc, 1);
        end
        in_flight = 0;
        fin_cyc = cyc;
        n_fins++;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int e0, f0, a0, na, nb, kind;
    cmd_t c;
    rst_n = 0; init_done = 0;
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    repeat (3) @(posedge mem_clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1; init_done = 1;
    @(posedge mem_clk); #1;

    // Single 128-word write on port 0.
    cq0.push_back('{wr: 1'b1, rd: 1'b0, len: 10'd128, addr: 24'h0});
    plan_order(1, 0);
    run_both();
    chk("s1_acks", n_acks, 1);
    chk("s1_fins", n_fins, 1);

    // Fresh reset so port 0 is preferred, then 2+2 contending reads.
    rst_n = 0; repeat (2) @(posedge mem_clk); #1; rst_n = 1;
    model_last = 1'b1;
    cq0.push_back('{wr: 1'b0, rd: 1'b1, len: 10'd4, addr: 24'h100});
    cq0.push_back('{wr: 1'b0, rd: 1'b1, len: 10'd4, addr: 24'h200});
    cq1.push_back('{wr: 1'b0, rd: 1'b1, len: 10'd4, addr: 24'h300});
    cq1.push_back('{wr: 1'b0, rd: 1'b1, len: 10'd4, addr: 24'h400});
    plan_order(2, 2);
    run_both();
    chk("s2_order_done", exp_q.size(), 0);

    // Port 1 granted last: p0 write beats p1 read, p1 follows after one idle cycle.
    cq0.push_back('{wr: 1'b1, rd: 1'b0, len: 10'd8, addr: 24'h10});
    cq1.push_back('{wr: 1'b0, rd: 1'b1, len: 10'd6, addr: 24'h20});
    plan_order(1, 1);
    run_both();
    chk("s3_order_done", exp_q.size(), 0);
    chk("s3_b2b_gap", last_gap, 1);

    // Zero-length burst on port 1 never reaches the engine.
    e0 = eng_bursts;
    cq1.push_back('{wr: 1'b1, rd: 1'b1, len: 10'd0, addr: 24'h55});
    plan_order(0, 1);
    run_both();
    chk("s4_no_engine_req", eng_bursts, e0);

    // Engine strobes while idle are swallowed.
    f0 = n_fins;
    stray_req++;
    repeat (3) @(posedge mem_clk);
    #1;
    chk("s4_stray_no_fin", n_fins, f0);

    // No grant while calibration is pending; grant as soon as it completes.
    init_done = 0;
    a0 = n_acks;
    f0 = n_fins;
    cq0.push_back('{wr: 1'b0, rd: 1'b1, len: 10'd16, addr: 24'h777});
    plan_order(1, 0);
    fork run_port(0); join_none
    repeat (5) @(posedge mem_clk);
    #1;
    chk("s5_no_ack_init_low", n_acks, a0);
    init_done = 1;
    #1;
    chk("s5_ack_on_init", p0_ack, 1);
    wait_state(BUSY);
    init_done = 0;
    wait_ports_idle();
    chk("s5_fin_init_low", n_fins, f0 + 1);
    init_done = 1;

    // Reset while a burst is in flight.
    cq1.push_back('{wr: 1'b0, rd: 1'b1, len: 10'd60, addr: 24'habc});
    plan_order(0, 1);
    fork run_port(1); join_none
    wait_state(BUSY);
    repeat (3) @(posedge mem_clk);
    #3;
    rst_n = 0;
    #1;
    check_outputs_zero("busy_reset");
    exp_q.delete();
    model_last = 1'b1;
    repeat (3) @(posedge mem_clk);
    #1;
    wait_ports_idle();
    rst_n = 1;
    @(posedge mem_clk); #1;

    // Random contention: port 0 must win first after reset, then alternate.
    na = $urandom_range(2, 4);
    nb = $urandom_range(2, 4);
    for (int i = 0; i < na + nb; i++) begin
      kind   = $urandom_range(0, 2);
      c.wr   = (kind != 1);
      c.rd   = (kind != 0);
      c.len  = LW'($urandom_range(1, 24));
      c.addr = AW'($urandom);
      if (i < na) cq0.push_back(c); else cq1.push_back(c);
    end
    plan_order(na, nb);
    run_both();
    chk("rand_order_done", exp_q.size(), 0);
    chk("rand_all_finished", in_flight, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
